// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and its consumers
// (colour logic and the video scaler stage).
interface vga_timing_if;
  logic       pix_ce;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       vga_h_blank;
  logic       vga_v_blank;
  logic       active;
  logic       line_start;
  logic       frame_start;

  modport master (
    output pix_ce, h_count, v_count, vga_h_sync, vga_v_sync,
           vga_h_blank, vga_v_blank, active, line_start, frame_start
  );

  modport slave (
    input  pix_ce, h_count, v_count, vga_h_sync, vga_v_sync,
           vga_h_blank, vga_v_blank, active, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock-enable, h/v counters, sync/blank strobes
// and line/frame start pulses, all registered together so they never skew.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic         Clk,
  input  logic         sys_reset,
  vga_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_BLANK_AT = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLANK_AT = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  DIV_LAST   = 3'(CLK_DIV - 1);
  localparam logic        SYNC_ON    = 1'(SYNC_POL);

  // Compared one bit wider so a window ending exactly at 1024 still decodes.
  function automatic logic at_or_above(input logic [9:0] x, input logic [10:0] lo);
    return {1'b0, x} >= lo;
  endfunction

  function automatic logic in_window(input logic [9:0] x, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, x} >= lo) && ({1'b0, x} < hi);
  endfunction

  function automatic logic sync_level(input logic on);
    return on ? SYNC_ON : ~SYNC_ON;
  endfunction

  logic [2:0] div_q;
  logic       pix_ce_p1;
  logic [9:0] h_p1;
  logic [9:0] v_p1;
  logic       hs_p1;
  logic       vs_p1;
  logic       hb_p1;
  logic       vb_p1;
  logic       act_p1;
  logic       ls_p1;
  logic       fs_p1;

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hb_nxt;
  logic       vb_nxt;

  // Stage 0: next raster position, advanced only on a pixel enable
  always_comb begin
    h_nxt  = h_p1;
    v_nxt  = v_p1;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (pix_ce_p1) begin
      if (h_p1 == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        if (v_p1 == V_LAST) begin
          v_nxt  = '0;
          v_wrap = 1'b1;
        end else begin
          v_nxt = v_p1 + 10'd1;
        end
      end else begin
        h_nxt = h_p1 + 10'd1;
      end
    end
  end

  assign hb_nxt = at_or_above(h_nxt, H_BLANK_AT);
  assign vb_nxt = at_or_above(v_nxt, V_BLANK_AT);

  // Stage 1: counters and every strobe decoded from the same next position
  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) begin
      div_q     <= '0;
      pix_ce_p1 <= 1'b0;
      h_p1      <= '0;
      v_p1      <= '0;
      hs_p1     <= ~SYNC_ON;
      vs_p1     <= ~SYNC_ON;
      hb_p1     <= 1'b0;
      vb_p1     <= 1'b0;
      act_p1    <= 1'b1;
      ls_p1     <= 1'b0;
      fs_p1     <= 1'b0;
    end else begin
      div_q     <= (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
      pix_ce_p1 <= (div_q == DIV_LAST);
      h_p1      <= h_nxt;
      v_p1      <= v_nxt;
      hs_p1     <= sync_level(in_window(h_nxt, H_SYNC_BEG, H_SYNC_END));
      vs_p1     <= sync_level(in_window(v_nxt, V_SYNC_BEG, V_SYNC_END));
      hb_p1     <= hb_nxt;
      vb_p1     <= vb_nxt;
      act_p1    <= ~hb_nxt & ~vb_nxt;
      ls_p1     <= h_wrap;
      fs_p1     <= v_wrap;
    end
  end

  assign vid.pix_ce      = pix_ce_p1;
  assign vid.h_count     = h_p1;
  assign vid.v_count     = v_p1;
  assign vid.vga_h_sync  = hs_p1;
  assign vid.vga_v_sync  = vs_p1;
  assign vid.vga_h_blank = hb_p1;
  assign vid.vga_v_blank = vb_p1;
  assign vid.active      = act_p1;
  assign vid.line_start  = ls_p1;
  assign vid.frame_start = fs_p1;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates raster timing for the game video path: pixel clock-enable, horizontal/vertical counters, sync and blank strobes. Sits directly upstream of the colour logic and the MiST video scaler stage. That stage consumes vga_h_sync, vga_v_sync, vga_h_blank and vga_v_blank; the colour logic consumes h_count and v_count to produce R/G/B. Defaults give 640x480@60 from a 50 MHz system clock divided by 2.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, Clk cycles per pixel (1..8)
SYNC_POL, 0, active level of both syncs (0 = active-low)

Ports:
Clk  in  1  system clock
sys_reset  in  1  asynchronous active-low reset
pix_ce  out  1  one-Clk pulse per pixel
h_count  out  10  current pixel column, 0..H_TOTAL-1
v_count  out  10  current line, 0..V_TOTAL-1
vga_h_sync  out  1  horizontal sync, level per SYNC_POL
vga_v_sync  out  1  vertical sync, level per SYNC_POL
vga_h_blank  out  1  high outside horizontal active region
vga_v_blank  out  1  high outside vertical active region
active  out  1  ~vga_h_blank & ~vga_v_blank
line_start  out  1  one-Clk pulse when h_count becomes 0
frame_start  out  1  one-Clk pulse when h_count and v_count both become 0

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low: sys_reset low clears all state immediately; release is sampled on Clk.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; out-of-range values are a configuration error and need not be handled.
- Reset values:
  - div counter = 0, pix_ce = 0.
  - h_count = 0, v_count = 0.
  - vga_h_sync = vga_v_sync = ~SYNC_POL (inactive).
  - vga_h_blank = vga_v_blank = 0, active = 1.
  - line_start = 0, frame_start = 0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_ce is registered high on the Clk cycle where div wraps: exactly one cycle in every CLK_DIV.
  - With CLK_DIV = 1, pix_ce is high on every cycle after the first post-reset edge.
  - First pix_ce arrives CLK_DIV cycles after reset release.
- Counters advance only on Clk edges where pix_ce is sampled high:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count at V_TOTAL-1 wraps to 0 on the same edge that h_count wraps.
- All outputs are registered and decoded from the next-state counter values, so every output is coherent with the h_count/v_count it is presented alongside (zero skew between them).
- Decode, with h = h_count and v = v_count:
  - vga_h_blank = (h ≥ H_ACTIVE).
  - vga_h_sync active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vga_v_blank = (v ≥ V_ACTIVE).
  - vga_v_sync active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491). v-sync edges change together with the h_count wrap to 0.
- Pulses:
  - line_start is high for exactly one Clk cycle, the cycle on which h_count first shows 0.
  - frame_start is high on that same cycle only when v_count also shows 0.
  - Neither pulse asserts at reset release; the first frame_start comes after one full frame.
- Outputs hold their values between pix_ce cycles. Only pix_ce, line_start and frame_start are single-cycle pulses.
- Reset mid-line: all state returns to reset values asynchronously. After release, timing restarts at (0,0) with no partial-pixel carry-over.

Test Plan:
- Reset held low for 5 cycles, then released:
  - during reset, all outputs equal the reset values listed above;
  - first pix_ce occurs 2 Clk cycles after release;
  - h_count = 1 after that first pix_ce.
- Free-run one line:
  - line_start pulses are 1600 Clk cycles apart;
  - vga_h_blank rises at h = 640 and falls at h = 0;
  - vga_h_sync is low for h = 656..751 (96 pixels, 192 Clk cycles).
- Free-run two frames:
  - frame_start pulses are exactly 840000 Clk cycles apart;
  - vga_v_blank is high for v = 480..524;
  - vga_v_sync is low for v = 490..491 only;
  - v_count never exceeds 524.
- Wrap boundary: at (h, v) = (799, 524), the next pix_ce gives (0, 0); line_start = 1 and frame_start = 1 on the same cycle.
- Apply sys_reset low asynchronously (not aligned to Clk) at h = 700, v = 300:
  - counters and syncs clear without waiting for a Clk edge;
  - after release, timing restarts at h = 0, v = 0.
- Parameter override CLK_DIV = 1, SYNC_POL = 1:
  - pix_ce is continuously high after the first post-reset cycle;
  - syncs are active-high over the same windows;
  - frame period is 420000 Clk cycles.
